// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch squash,
// memory-wait freeze with timeout halt, saturating debug counters.
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [4:0]       idex_rt,
  input  logic             idex_Mread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [2:0] LL1 = 3'(LOAD_LAT - 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    HALT
  } state_t;

  state_t state, state_n;
  state_t ret, ret_n;
  state_t eff;
  logic [2:0] left, left_n;
  logic [WW-1:0] wcnt, wcnt_n, wbase;
  logic hazard, memstall;
  logic fl_inc, st_inc, to_set;

  assign hazard = idex_Mread && (idex_rt != 5'd0) &&
    ((idex_rt == ifid_rs) ||
     (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign memstall = mem_req && !mem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    state_n     = state;
    ret_n       = ret;
    left_n      = left;
    wcnt_n      = wcnt;
    wbase       = '0;
    fl_inc      = 1'b0;
    to_set      = 1'b0;
    // after a memory wait, act as the state we were frozen in
    eff = (state == MEM_WAIT) ? ret : state;
    if (state == HALT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (memstall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_n     = MEM_WAIT;
      if (state != MEM_WAIT) ret_n = state;
      wbase  = (state == MEM_WAIT) ? wcnt : '0;
      wcnt_n = (&wbase) ? wbase : wbase + 1'b1;
      if (TIMEOUT != 0 && wcnt_n >= TO) begin
        state_n = HALT;
        to_set  = 1'b1;
      end
    end else begin
      wcnt_n  = '0;
      state_n = RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        fl_inc     = 1'b1;
        left_n     = '0;
      end else if (eff == LOAD_STALL) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        left_n     = left - 3'd1;
        if (left > 3'd1) state_n = LOAD_STALL;
      end else if (hazard) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (LOAD_LAT > 1) begin
          left_n  = LL1;
          state_n = LOAD_STALL;
        end
      end
    end
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_flush  = 1'b1;
      exmem_write = 1'b0;
      fl_inc      = 1'b0;
    end
  end

  assign st_inc = (state != HALT) && !pc_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      ret         <= RUN;
      left        <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      left  <= left_n;
      wcnt  <= wcnt_n;
      if (to_set) mem_timeout <= 1'b1;
      if (st_inc && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (fl_inc && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
